// File: rtl/hdmi_rd_sched_if.sv
// Read-request channel between the line-prefetch scheduler and the DDR read arbiter.
interface hdmi_rd_sched_if #(
  parameter int ADDR_W = 28
);
  logic              o_rd_req;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              i_rd_ack;
  logic              i_rd_done;

  modport master (output o_rd_req, o_rd_addr, input i_rd_ack, i_rd_done);
  modport slave  (input o_rd_req, o_rd_addr, output i_rd_ack, i_rd_done);
endinterface

// File: rtl/hdmi_rd_sched.sv
// HDMI line-prefetch scheduler: keeps up to PREFETCH line reads ahead of the scan,
// picks the frame bank at frame start, and flags lines shown before their data landed.
module hdmi_rd_sched #(
  parameter int V_ACT       = 720,
  parameter int LINE_BYTES  = 2560,
  parameter int FRAME_BYTES = 2097152,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 28,
  parameter int PREFETCH    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_vsync,
  input  logic                  i_de,
  input  logic [1:0]            i_bank,
  hdmi_rd_sched_if.master       rd,
  output logic                  o_busy,
  output logic                  o_underrun,
  output logic                  o_flush
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_REQ, S_WAIT, S_DONE, S_FLUSH} state_t;

  state_t            state, state_nxt;
  logic              vs_d, de_d;
  logic [1:0]        bank, bank_nxt;
  logic [9:0]        req_cnt, done_cnt, disp_cnt;
  logic [9:0]        req_nxt, done_nxt, disp_nxt;
  logic              fs_pend, fs_pend_nxt;
  logic              underrun_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              fs, ls, le, ack, done_ok;

  assign fs      = i_vsync & ~vs_d;
  assign ls      = i_de & ~de_d;
  assign le      = ~i_de & de_d;
  assign ack     = (state == S_REQ) & rd.i_rd_ack;
  assign done_ok = rd.i_rd_done & (done_cnt != req_cnt);

  // Evaluated as req < disp + PREFETCH so a scan that has overtaken fetching still grants credit.
  function automatic logic has_credit(input logic [9:0] req, input logic [9:0] disp);
    return (req < 10'(V_ACT)) && ({1'b0, req} < ({1'b0, disp} + 11'(PREFETCH)));
  endfunction

  always_comb begin
    state_nxt    = state;
    bank_nxt     = bank;
    fs_pend_nxt  = fs_pend;
    req_nxt      = req_cnt + 10'(ack);
    done_nxt     = done_cnt + 10'(done_ok);
    disp_nxt     = (le && (disp_cnt < 10'(V_ACT))) ? disp_cnt + 10'd1 : disp_cnt;
    underrun_nxt = o_underrun | (o_busy & ls & (done_cnt <= disp_cnt));

    unique case (state)
      S_IDLE: begin
        if (fs) state_nxt = S_START;
      end
      S_START: begin
        bank_nxt     = (i_bank == 2'd3) ? 2'd0 : i_bank;
        req_nxt      = '0;
        done_nxt     = '0;
        disp_nxt     = '0;
        fs_pend_nxt  = 1'b0;
        underrun_nxt = 1'b0;
        state_nxt    = S_REQ;
      end
      S_REQ: begin
        // A frame start here waits for the outstanding request to be accepted first.
        if (fs) begin
          fs_pend_nxt  = 1'b1;
          underrun_nxt = 1'b1;
        end
        if (ack) begin
          if (fs || fs_pend) begin
            fs_pend_nxt = 1'b0;
            state_nxt   = (done_nxt != req_nxt) ? S_FLUSH : S_START;
          end else if (!has_credit(req_nxt, disp_nxt)) begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (fs) begin
          underrun_nxt = 1'b1;
          state_nxt    = (done_nxt != req_nxt) ? S_FLUSH : S_START;
        end else if (has_credit(req_cnt, disp_cnt)) begin
          state_nxt = S_REQ;
        end else if ((req_cnt == 10'(V_ACT)) && (done_cnt == 10'(V_ACT))) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (fs) state_nxt = S_START;
      end
      S_FLUSH: begin
        if (done_cnt == req_cnt) state_nxt = S_START;
      end
      default: state_nxt = S_IDLE;
    endcase

    addr_nxt = ADDR_W'(BASE_ADDR)
             + ADDR_W'(bank_nxt) * ADDR_W'(FRAME_BYTES)
             + ADDR_W'(req_nxt) * ADDR_W'(LINE_BYTES);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      vs_d         <= 1'b0;
      de_d         <= 1'b0;
      bank         <= '0;
      req_cnt      <= '0;
      done_cnt     <= '0;
      disp_cnt     <= '0;
      fs_pend      <= 1'b0;
      rd.o_rd_req  <= 1'b0;
      rd.o_rd_addr <= '0;
      o_busy       <= 1'b0;
      o_underrun   <= 1'b0;
      o_flush      <= 1'b0;
    end else begin
      state       <= state_nxt;
      vs_d        <= i_vsync;
      de_d        <= i_de;
      bank        <= bank_nxt;
      req_cnt     <= req_nxt;
      done_cnt    <= done_nxt;
      disp_cnt    <= disp_nxt;
      fs_pend     <= fs_pend_nxt;
      rd.o_rd_req <= (state_nxt == S_REQ);
      if (state_nxt == S_REQ) rd.o_rd_addr <= addr_nxt;
      o_busy      <= (state_nxt == S_START) || (state_nxt == S_REQ) ||
                     (state_nxt == S_WAIT)  || (state_nxt == S_FLUSH);
      o_underrun  <= underrun_nxt;
      o_flush     <= (state_nxt == S_FLUSH);
    end
  end

endmodule

// File: tb/tb_hdmi_rd_sched.sv
// Directed bench for hdmi_rd_sched: a small arbiter/memory model answers acks with
// delayed in-order done pulses while the stimulus walks through frame scenarios.
module tb_hdmi_rd_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_vsync;
  logic       i_de;
  logic [1:0] i_bank;
  logic       o_busy, o_underrun, o_flush;

  hdmi_rd_sched_if #(.ADDR_W(28)) bus ();

  hdmi_rd_sched #(
    .V_ACT(720), .LINE_BYTES(2560), .FRAME_BYTES(2097152),
    .BASE_ADDR(0), .ADDR_W(28), .PREFETCH(2)
  ) dut (
    .clk(clk), .rstn(rstn), .i_vsync(i_vsync), .i_de(i_de), .i_bank(i_bank),
    .rd(bus), .o_busy(o_busy), .o_underrun(o_underrun), .o_flush(o_flush)
  );

  always #5 clk = ~clk;

  int          nvec = 0, nerr = 0;
  int          cyc = 0;
  int          req_seen = 0, done_seen = 0, done_fired = 0;
  int          ur_cycles = 0, flush_dones = 0, busy_fall_dones = -1;
  logic [27:0] last_addr = '0;
  logic        busy_prev = 1'b0;
  int          done_delay = 100;
  int          hold_idx = -1;
  bit          hold_all = 1'b0;
  int          due_q[$];

  // Memory model: observes the bus at the edge, answers with done pulses just after it.
  always begin
    @(posedge clk);
    cyc++;
    if (rstn) begin
      if (bus.o_rd_req && bus.i_rd_ack) begin
        due_q.push_back(cyc + done_delay);
        req_seen++;
        last_addr = bus.o_rd_addr;
      end
      if (bus.i_rd_done) begin
        done_seen++;
        if (o_flush) flush_dones++;
      end
      if (o_underrun) ur_cycles++;
      if (busy_prev && !o_busy) busy_fall_dones = done_seen;
      busy_prev = o_busy;
    end
    #1;
    if (!rstn) begin
      due_q.delete();
      bus.i_rd_done = 1'b0;
    end else if (bus.i_rd_done) begin
      bus.i_rd_done = 1'b0;
    end else if (due_q.size() != 0 && !hold_all && done_fired != hold_idx && due_q[0] <= cyc + 1) begin
      bus.i_rd_done = 1'b1;
      done_fired++;
      void'(due_q.pop_front());
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic line(input int hi, input int lo);
    i_de = 1'b1;
    ticks(hi);
    i_de = 1'b0;
    ticks(lo);
  endtask

  int req_base, done_base, ur_base, fl_base;

  initial begin
    rstn = 1'b0; i_vsync = 1'b0; i_de = 1'b0; i_bank = 2'd0; bus.i_rd_ack = 1'b0;
    ticks(3);
    check("rst_req",      32'(bus.o_rd_req),  32'd0);
    check("rst_addr",     32'(bus.o_rd_addr), 32'd0);
    check("rst_busy",     32'(o_busy),        32'd0);
    check("rst_underrun", 32'(o_underrun),    32'd0);
    check("rst_flush",    32'(o_flush),       32'd0);
    rstn = 1'b1;
    ticks(2);

    // Frame 1: bank 1, ack tied high, done 100 cycles after each ack, 720 lines.
    req_base = req_seen; done_base = done_seen; ur_base = ur_cycles;
    bus.i_rd_ack = 1'b1; i_bank = 2'd1; i_vsync = 1'b1;
    ticks(1);
    i_vsync = 1'b0;
    check("f1_start_req",  32'(bus.o_rd_req),  32'd0);
    check("f1_start_busy", 32'(o_busy),        32'd1);
    ticks(1);
    check("f1_req0",       32'(bus.o_rd_req),  32'd1);
    check("f1_addr0",      32'(bus.o_rd_addr), 32'h0020_0000);
    ticks(1);
    check("f1_req1",       32'(bus.o_rd_req),  32'd1);
    check("f1_addr1",      32'(bus.o_rd_addr), 32'h0020_0A00);
    ticks(1);
    check("f1_req_drop",   32'(bus.o_rd_req),  32'd0);
    ticks(130);
    for (int l = 0; l < 720; l++) line(20, 50);
    check("f1_nreq",       32'(req_seen - req_base),        32'd720);
    check("f1_last_addr",  32'(last_addr),                  32'h003C_1600);
    check("f1_busy_end",   32'(o_busy),                     32'd0);
    check("f1_busy_fall",  32'(busy_fall_dones - done_base), 32'd720);
    check("f1_ur_cycles",  32'(ur_cycles - ur_base),         32'd0);
    check("f1_req_idle",   32'(bus.o_rd_req),               32'd0);

    // Frame 2: bank 2, ack withheld 50 cycles, then line 3's done withheld past its de rise.
    bus.i_rd_ack = 1'b0; done_delay = 5; hold_idx = done_fired + 3;
    i_bank = 2'd2; i_vsync = 1'b1;
    ticks(1);
    i_vsync = 1'b0;
    check("f2_start_busy", 32'(o_busy), 32'd1);
    ticks(1);
    for (int i = 0; i < 50; i++) begin
      check("f2_hold_req",  32'(bus.o_rd_req),  32'd1);
      check("f2_hold_addr", 32'(bus.o_rd_addr), 32'h0040_0000);
      ticks(1);
    end
    bus.i_rd_ack = 1'b1;
    ticks(15);
    for (int l = 0; l < 3; l++) line(10, 10);
    check("f2_ur_pre",     32'(o_underrun), 32'd0);
    i_de = 1'b1;
    ticks(1);
    check("f2_ur_set",     32'(o_underrun), 32'd1);
    hold_idx = -1;
    ticks(9);
    i_de = 1'b0;
    ticks(10);
    line(10, 10);
    line(10, 10);
    check("f2_ur_sticky",  32'(o_underrun), 32'd1);
    ticks(20);

    // Frame 3: i_bank=3 selects bank 0; vsync with nothing outstanding goes straight to START.
    req_base = req_seen;
    i_bank = 2'd3; i_vsync = 1'b1;
    ticks(1);
    i_vsync = 1'b0;
    check("f3_start_ur",    32'(o_underrun),   32'd1);
    check("f3_start_flush", 32'(o_flush),      32'd0);
    check("f3_start_req",   32'(bus.o_rd_req), 32'd0);
    ticks(1);
    check("f3_ur_clear",    32'(o_underrun),    32'd0);
    check("f3_req0",        32'(bus.o_rd_req),  32'd1);
    check("f3_addr0",       32'(bus.o_rd_addr), 32'd0);
    ur_base = ur_cycles;
    ticks(15);
    for (int l = 0; l < 398; l++) line(10, 10);
    hold_all = 1'b1;
    line(10, 10);
    line(10, 10);
    check("f3_ur_cycles",   32'(ur_cycles - ur_base), 32'd0);
    check("f3_nreq",        32'(req_seen - req_base), 32'd402);
    check("f3_last_addr",   32'(last_addr),           32'h000F_AA00);

    // vsync at line 400 with two reads outstanding: flush, then new frame on bank 1.
    i_bank = 2'd1; i_vsync = 1'b1;
    ticks(1);
    i_vsync = 1'b0;
    check("fl_flush",       32'(o_flush),      32'd1);
    check("fl_ur",          32'(o_underrun),   32'd1);
    check("fl_busy",        32'(o_busy),       32'd1);
    check("fl_req",         32'(bus.o_rd_req), 32'd0);
    fl_base = flush_dones;
    ticks(10);
    check("fl_flush_held",  32'(o_flush),      32'd1);
    bus.i_rd_ack = 1'b0;
    hold_all = 1'b0;
    for (int i = 0; i < 40 && o_flush; i++) ticks(1);
    check("fl_exit",        32'(o_flush),                 32'd0);
    check("fl_dones",       32'(flush_dones - fl_base),   32'd2);
    check("fl_ur_in_start", 32'(o_underrun),              32'd1);
    check("fl_start_req",   32'(bus.o_rd_req),            32'd0);
    ticks(1);
    check("nf_req",         32'(bus.o_rd_req),  32'd1);
    check("nf_addr",        32'(bus.o_rd_addr), 32'h0020_0000);
    check("nf_ur",          32'(o_underrun),    32'd0);

    // Asynchronous reset while a request is pending.
    rstn = 1'b0;
    #1;
    check("ar_req",  32'(bus.o_rd_req),  32'd0);
    check("ar_addr", 32'(bus.o_rd_addr), 32'd0);
    check("ar_busy", 32'(o_busy),        32'd0);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
